// File: rtl/fixed_div_iter.sv
// Iterative restoring divider for sign-magnitude fixed-point operands.
// Retires R quotient bits per cycle; optional rounding, saturation, abort.
module fixed_div_iter #(
    parameter int N = 32,
    parameter int Q = 16,
    parameter int R = 1
) (
    input  logic         clk_i,
    input  logic         nrst_i,
    input  logic         start_i,
    input  logic         flush_i,
    input  logic         round_i,
    input  logic [N-1:0] opA_i,
    input  logic [N-1:0] opB_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic         dz_o,
    output logic         ovf_o
);

    localparam int K  = N - 1 + Q;
    localparam int C  = (K + R - 1) / R;
    localparam int W  = C * R;
    localparam int CW = $clog2(C + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [N-2:0]   bm_q, bm_d;
    logic           sign_q, sign_d;
    logic           round_q, round_d;
    logic           dz_pend_q, dz_pend_d;
    logic [N-1:0]   result_q, result_d;
    logic           dz_q, dz_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;

    logic [W-1:0]   dvd_init;
    logic [N-1:0]   rem_step;
    logic [N-1:0]   rem_sh;
    logic [R-1:0]   qbits;
    logic           inc;
    logic [W:0]     quo_rnd;
    logic           big;
    logic [N-2:0]   fin_mag;
    logic           fin_ovf;
    logic [N-1:0]   fin_result;

    // Dividend magnitude pre-shifted by Q, zero-padded at the top to W bits.
    always_comb begin
        dvd_init = '0;
        dvd_init[K-1:0] = {opA_i[N-2:0], {Q{1'b0}}};
    end

    // R chained restoring steps, MSB-first; the remainder always stays below
    // the divisor, so shifting left never loses its top bit.
    always_comb begin
        rem_step = rem_q;
        rem_sh   = '0;
        qbits    = '0;
        for (int i = 0; i < R; i++) begin
            rem_sh = {rem_step[N-2:0], dvd_q[W-1-i]};
            if (rem_sh >= {1'b0, bm_q}) begin
                rem_step       = rem_sh - {1'b0, bm_q};
                qbits[R-1-i]   = 1'b1;
            end else begin
                rem_step = rem_sh;
            end
        end
    end

    // Final rounding and saturation; rounding compare is done at N+1 bits.
    always_comb begin
        inc     = round_q && ({rem_q, 1'b0} >= {2'b00, bm_q});
        quo_rnd = {1'b0, quo_q} + {{W{1'b0}}, inc};
        big     = |quo_rnd[W:N-1];
        if (dz_pend_q) begin
            fin_mag = '1;
            fin_ovf = 1'b0;
        end else if (big) begin
            fin_mag = '1;
            fin_ovf = 1'b1;
        end else begin
            fin_mag = quo_rnd[N-2:0];
            fin_ovf = 1'b0;
        end
        fin_result = {sign_q & (|fin_mag), fin_mag};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        quo_d     = quo_q;
        bm_d      = bm_q;
        sign_d    = sign_q;
        round_d   = round_q;
        dz_pend_d = dz_pend_q;
        result_d  = result_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rem_d     = '0;
                        dvd_d     = dvd_init;
                        quo_d     = '0;
                        bm_d      = opB_i[N-2:0];
                        sign_d    = opA_i[N-1] ^ opB_i[N-1];
                        round_d   = round_i;
                        dz_pend_d = ~(|opB_i[N-2:0]);
                        if (dz_pend_d) begin
                            state_d = S_FIN;
                        end else begin
                            state_d = S_CALC;
                            cnt_d   = CW'(C - 1);
                        end
                    end
                end
                S_CALC: begin
                    rem_d = rem_step;
                    dvd_d = dvd_q << R;
                    quo_d = {quo_q[W-R-1:0], qbits};
                    if (cnt_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_FIN: begin
                    result_d = fin_result;
                    dz_d     = dz_pend_q;
                    ovf_d    = fin_ovf;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            quo_q     <= '0;
            bm_q      <= '0;
            sign_q    <= 1'b0;
            round_q   <= 1'b0;
            dz_pend_q <= 1'b0;
            result_q  <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            quo_q     <= quo_d;
            bm_q      <= bm_d;
            sign_q    <= sign_d;
            round_q   <= round_d;
            dz_pend_q <= dz_pend_d;
            result_q  <= result_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign dz_o     = dz_q;
    assign ovf_o    = ovf_q;

endmodule

// File: doc/fixed_div_iter.md
# fixed_div_iter

Parametrised iterative divider for sign-magnitude fixed-point operands in the timing datapath. It replaces the single-bit-per-cycle level-sensitive divider with a pulse-start/pulse-done handshake, a configurable radix (1, 2 or 4 quotient bits per cycle), optional round-to-nearest, divide-by-zero and overflow flags with saturation, and a synchronous abort. The block sits between the timing-parameter registers and the consumer that needs ratio values, such as period/step computations.

## Interface
- N, 32: total word width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- Q, 16: fractional bits of the magnitude; requires 1 <= Q <= N-2.
- R, 1: quotient bits retired per compute cycle; legal values are 1, 2 and 4.
- clk_i  in  1  clock; all state changes on the rising edge.
- nrst_i  in  1  reset; one clock, asynchronous, active-low.
- start_i  in  1  request; accepted only when ready_o=1.
- flush_i  in  1  synchronous abort; has priority over start_i.
- round_i  in  1  0=truncate, 1=round half up; sampled at accept.
- opA_i  in  N  dividend (sign-magnitude); sampled at accept.
- opB_i  in  N  divisor (sign-magnitude); sampled at accept.
- ready_o  out  1  block is idle and can accept a request.
- done_o  out  1  one-cycle pulse; result_o and flags are valid from this cycle onward.
- result_o  out  N  quotient (sign-magnitude, Q fractional bits); held until the next done_o.
- dz_o  out  1  last result was a divide by zero; held with result_o.
- ovf_o  out  1  last result saturated on overflow; held with result_o.

## Operation
- Magnitudes: Am = opA_i[N-2:0] and Bm = opB_i[N-2:0]. Sign S = opA_i[N-1] ^ opB_i[N-1].
- Quotient magnitude Qm = floor((Am << Q) / Bm). It is computed as K = N-1+Q bits, MSB first, by restoring division.
- The dividend is zero-padded at the top to C*R bits, where C = ceil(K/R). The remainder register is N bits wide.
- Each compute cycle performs R chained shift/compare/subtract steps.
- States:
  - IDLE: ready_o=1. On start_i (and not flush_i), load operands. If Bm=0, go to FIN; otherwise go to CALC with cnt=C-1.
  - CALC: retire R bits per cycle. When cnt=0, go to FIN; otherwise decrement cnt.
  - FIN: apply rounding and saturation, register result_o, dz_o and ovf_o, pulse done_o, then return to IDLE.
- Rounding (round_i=1): if 2*rem >= Bm, then Qm = Qm+1. The comparison is made at N+1-bit width.
- Overflow: if Qm (after rounding) > 2^(N-1)-1, the magnitude becomes all ones and ovf_o=1.
- Divide by zero: magnitude becomes all ones, dz_o=1, ovf_o=0. The sign is still S.
- Zero magnitude result: the sign is forced to 0, so negative zero is never output.
- flush_i=1 in any state sends the block to IDLE at the next edge. No done_o is produced, and result_o, dz_o and ovf_o keep their previous values.
- start_i while ready_o=0 is ignored. No queueing.

## Timing
- Reset values: ready_o=1, done_o=0, result_o=0, dz_o=0, ovf_o=0. State is IDLE and cnt=0.
- Reset asserted mid-operation returns the block to IDLE immediately. The request is lost.
- Let E0 be the accept edge. The CALC edges are E1..EC. FIN completes at edge E(C+1), after which done_o=1 for exactly one cycle.
- Latency is C+1 edges. For N=32, Q=16: R=1 gives 48 edges, R=2 gives 24+1=25, R=4 gives 12+1=13.
- Divide by zero takes 1 edge: done_o is high after E1.
- ready_o is 0 from E0 until FIN completes. ready_o=1 in the same cycle as done_o=1.
- Back-to-back operation: start_i in the done_o cycle is accepted.
- flush_i and start_i asserted together in IDLE: flush wins, nothing is accepted, ready_o stays 1.

## Test plan
All vectors use N=32, Q=16.
- 0x00030000 / 0x00020000, round_i=0, for each R -> result 0x00018000, dz=0, ovf=0. done_o after exactly 48 / 25 / 13 edges.
- 0x80030000 / 0x00020000 -> 0x80018000. Then 0x00000000 / 0x80010000 -> 0x00000000 (no negative zero).
- 0x00020000 / 0x00030000 with round_i=0 -> 0x0000AAAA. The same operands with round_i=1 -> 0x0000AAAB.
- Overflow and divide by zero:
  - 0x40000000 / 0x00000100 -> 0x7FFFFFFF, ovf=1.
  - 0x00010000 / 0x80000000 -> 0xFFFFFFFF, dz=1, done_o after 1 edge.
- Abort: flush_i at cycle 10 of a 48-cycle op -> no done_o, ready_o=1 next cycle, result_o unchanged. start_i+flush_i together in IDLE -> ignored.
- Back-to-back, bus protocol and reset:
  - start_i in the done_o cycle -> second result after a further C+1 edges.
  - start_i while busy -> ignored.
  - nrst_i pulsed mid-CALC -> all outputs return to their reset values asynchronously.
